data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Round-robin arbiter that decides which compute core owns the shared data-memory channel set. It sits between the per-core LSU request-valid aggregates and the data memory controller. It grants one core at a time for a full 4-wide read or write transaction and holds the grant until that core releases it. A hold-time watchdog keeps a hung core from starving the others.

## Interface
Parameters:
- NUM_CORES, 4, number of requesting cores (>= 2)
- MAX_THREADS, 4, threads per core; a core requests only when all MAX_THREADS lanes are valid
- MAX_HOLD, 64, maximum BUSY cycles before forced release (>= 2)

Ports:
- clk  in  1  clock; all logic on posedge
- reset  in  1  synchronous, active-high
- core_read_req  in  NUM_CORES  bit c = all read_req_addr_val lanes of core c high
- core_write_req  in  NUM_CORES  bit c = all write_req_val lanes of core c high
- core_release  in  NUM_CORES  bit c pulses when core c reaches WRITEBACK (transaction consumed)
- grant_valid  out  1  a grant is active
- grant_core  out  $clog2(NUM_CORES)  index of granted core
- grant_onehot  out  NUM_CORES  one-hot of granted core; all zero when grant_valid=0
- grant_is_write  out  1  1 = write transaction, 0 = read
- busy  out  1  state is not IDLE
- timeout_err  out  1  sticky; set on watchdog-forced release

## Operation
- States: IDLE, BUSY, COOLDOWN. All outputs are registered.
- IDLE: form req = core_read_req | core_write_req.
  - If req != 0, pick the first set bit searching upward from rr_ptr, wrapping modulo NUM_CORES.
  - Register grant_core, grant_onehot, grant_valid=1. Set grant_is_write = core_write_req[pick]; write wins when a core asserts both.
  - Set rr_ptr = pick+1 (mod NUM_CORES) and go to BUSY.
  - If req == 0, stay in IDLE.
- BUSY: grant outputs stay frozen regardless of request changes. hold_cnt increments each cycle.
  - core_release[grant_core]=1: clear grant_valid, grant_onehot and grant_is_write; go to COOLDOWN. grant_core keeps its last value.
  - hold_cnt == MAX_HOLD-1 with no release: same clears, plus timeout_err<=1; go to COOLDOWN.
  - Release bits from non-granted cores are ignored.
- COOLDOWN: exactly one cycle so the channel controller can clear its lane registers. Reset hold_cnt=0 and go to IDLE unconditionally. Requests are not sampled here.
- core_release is ignored in IDLE and COOLDOWN.
- Reset values: state=IDLE, rr_ptr=0, hold_cnt=0, grant_valid=0, grant_core=0, grant_onehot=0, grant_is_write=0, busy=0, timeout_err=0.
- Reset mid-BUSY drops the grant immediately at the next edge. No partial state survives.
- hold_cnt width is $clog2(MAX_HOLD+1) and it never wraps. rr_ptr width matches grant_core, and its wrap uses an explicit compare for non-power-of-2 NUM_CORES.

## Timing
- Request sampled in IDLE at edge N; grant_valid=1 from edge N (visible in cycle N..N+1). Minimum request-to-grant latency is 1 cycle.
- Release sampled at edge K; grant_valid=0 after K. COOLDOWN runs K..K+1 and IDLE samples at K+2. Minimum release-to-next-grant latency is 2 edges.
- Watchdog: with the grant set at edge G and no release, the forced release occurs at edge G+MAX_HOLD.
- Release and watchdog in the same cycle: treat as a normal release; timeout_err is not set.
- busy=1 throughout BUSY and COOLDOWN.

## Structure
- Shared package (gpu_pkg):
  - Arbiter state encodings ARB_IDLE=2'd0, ARB_BUSY=2'd1, ARB_COOLDOWN=2'd2.
  - Default NUM_CORES/MAX_THREADS constants.
  - Existing compute-state localparams (WRITEBACK=4'd6) relocated here so the controller and core agree on core_release generation.
- Sub-module rr_priority_pick: purely combinational. Takes (req, rr_ptr) and returns (found, pick). Instantiated once in the arbiter.
- The lane-AND that produces core_read_req/core_write_req lives in the parent, not here.

## Test plan
- Reset, then core_read_req=4'b0100 -> one edge later grant_valid=1, grant_core=2, grant_onehot=4'b0100, grant_is_write=0.
- All four cores read-requesting continuously, each released 3 cycles after grant -> grant order 0,1,2,3,0, with exactly 2 idle edges between grants.
- Core 1 asserts read and write together -> grant_is_write=1. A release from core 3 during BUSY is ignored and the grant persists.
- MAX_HOLD=8, grant core 0 with no release -> grant drops 8 edges after grant, timeout_err=1 and sticky. The next grant goes to core 1 if it is requesting.
- Assert reset while BUSY with grant_core=3 -> all outputs at reset values next cycle. The following request from cores 0 and 3 grants core 0.
- Requests drop to 0 during BUSY -> grant held until release. After COOLDOWN, state=IDLE and busy=0.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared GPU definitions: arbiter state encodings, default core sizing and
// compute-state codes that the memory controller and cores both rely on.
package gpu_pkg;
  localparam logic [1:0] ARB_IDLE     = 2'd0;
  localparam logic [1:0] ARB_BUSY     = 2'd1;
  localparam logic [1:0] ARB_COOLDOWN = 2'd2;

  localparam int DEFAULT_NUM_CORES   = 4;
  localparam int DEFAULT_MAX_THREADS = 4;

  // Compute-core states; core_release is raised when a core enters WRITEBACK.
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] FETCH     = 4'd1;
  localparam logic [3:0] DECODE    = 4'd2;
  localparam logic [3:0] REQUEST   = 4'd3;
  localparam logic [3:0] WAIT      = 4'd4;
  localparam logic [3:0] EXECUTE   = 4'd5;
  localparam logic [3:0] WRITEBACK = 4'd6;
  localparam logic [3:0] DONE      = 4'd7;
endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority search: first set bit of req at or above
// rr_ptr, wrapping modulo NUM_CORES.
module rr_priority_pick #(
  parameter int NUM_CORES = 4,
  parameter int CW        = $clog2(NUM_CORES)
) (
  input  logic [NUM_CORES-1:0] req,
  input  logic [CW-1:0]        rr_ptr,
  output logic                 found,
  output logic [CW-1:0]        pick
);
  // Walk offsets from farthest to nearest so the nearest hit is the last write.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      int idx;
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (req[idx]) begin
        found = 1'b1;
        pick  = CW'(idx);
      end
    end
  end
endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin owner of the shared data-memory channels: one core holds the
// grant for a whole transaction, with a hold-time watchdog against hung cores.
module data_mem_arbiter
  import gpu_pkg::*;
#(
  parameter int NUM_CORES   = DEFAULT_NUM_CORES,
  parameter int MAX_THREADS = DEFAULT_MAX_THREADS,
  parameter int MAX_HOLD    = 64,
  parameter int CW          = $clog2(NUM_CORES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] core_read_req,
  input  logic [NUM_CORES-1:0] core_write_req,
  input  logic [NUM_CORES-1:0] core_release,
  output logic                 grant_valid,
  output logic [CW-1:0]        grant_core,
  output logic [NUM_CORES-1:0] grant_onehot,
  output logic                 grant_is_write,
  output logic                 busy,
  output logic                 timeout_err
);
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [1:0]           state;
  logic [CW-1:0]        rr_ptr;
  logic [HW-1:0]        hold_cnt;
  logic [NUM_CORES-1:0] req;
  logic                 found;
  logic [CW-1:0]        pick;
  logic [CW-1:0]        pick_next;
  logic [NUM_CORES-1:0] pick_onehot;
  logic                 released;
  logic                 expired;

  assign req = core_read_req | core_write_req;

  rr_priority_pick #(.NUM_CORES(NUM_CORES), .CW(CW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .found  (found),
    .pick   (pick)
  );

  // Explicit wrap so non-power-of-2 core counts rotate correctly.
  assign pick_next   = (pick == CW'(NUM_CORES - 1)) ? '0 : pick + CW'(1);
  assign pick_onehot = {{(NUM_CORES-1){1'b0}}, 1'b1} << pick;
  // grant_onehot masks out releases from cores that do not own the channel.
  assign released    = |(core_release & grant_onehot);
  assign expired     = (hold_cnt == HW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB_IDLE;
      rr_ptr         <= '0;
      hold_cnt       <= '0;
      grant_valid    <= 1'b0;
      grant_core     <= '0;
      grant_onehot   <= '0;
      grant_is_write <= 1'b0;
      busy           <= 1'b0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant_valid    <= 1'b1;
            grant_core     <= pick;
            grant_onehot   <= pick_onehot;
            grant_is_write <= core_write_req[pick];
            rr_ptr         <= pick_next;
            hold_cnt       <= '0;
            busy           <= 1'b1;
            state          <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (released || expired) begin
            grant_valid    <= 1'b0;
            grant_onehot   <= '0;
            grant_is_write <= 1'b0;
            if (!released) timeout_err <= 1'b1;
            state          <= ARB_COOLDOWN;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        ARB_COOLDOWN: begin
          hold_cnt <= '0;
          busy     <= 1'b0;
          state    <= ARB_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ARB_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed vector table, hand-written multi-cycle
// corner cases and a randomized run, all against a transaction-level model.
module tb_data_mem_arbiter;
  localparam int N    = 4;
  localparam int HOLD = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] core_read_req, core_write_req, core_release;
  logic         grant_valid, grant_is_write, busy, timeout_err;
  logic [1:0]   grant_core;
  logic [N-1:0] grant_onehot;

  data_mem_arbiter #(.NUM_CORES(N), .MAX_THREADS(4), .MAX_HOLD(HOLD)) dut (
    .clk(clk), .reset(reset),
    .core_read_req(core_read_req), .core_write_req(core_write_req),
    .core_release(core_release),
    .grant_valid(grant_valid), .grant_core(grant_core),
    .grant_onehot(grant_onehot), .grant_is_write(grant_is_write),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic cmp(string nm, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the channel, since which edge, and
  // whether we are in the one-edge gap after a release.
  int   edge_no = 0;
  int   g_edge  = 0;
  int   owner   = 0;
  int   last    = -1;
  bit   m_gv = 0, m_wr = 0, m_gap = 0, m_terr = 0;

  task automatic model_edge();
    logic [N-1:0] rq;
    edge_no++;
    rq = core_read_req | core_write_req;
    if (reset) begin
      m_gv = 0; m_wr = 0; m_gap = 0; m_terr = 0; owner = 0; last = -1;
    end else if (m_gap) begin
      m_gap = 0;
    end else if (m_gv) begin
      if (core_release[owner]) begin
        m_gv = 0; m_wr = 0; m_gap = 1;
      end else if (edge_no - g_edge == HOLD) begin
        m_gv = 0; m_wr = 0; m_gap = 1; m_terr = 1;
      end
    end else begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (last + 1 + k) % N;
        if (!m_gv && rq[c]) begin
          m_gv = 1; owner = c; last = c; g_edge = edge_no;
          m_wr = core_write_req[c];
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp("m_valid", int'(grant_valid), int'(m_gv));
    cmp("m_core", int'(grant_core), owner);
    cmp("m_onehot", int'(grant_onehot), m_gv ? (1 << owner) : 0);
    cmp("m_write", int'(grant_is_write), int'(m_wr));
    cmp("m_busy", int'(busy), int'(m_gv || m_gap));
    cmp("m_terr", int'(timeout_err), int'(m_terr));
  endtask

  task automatic drive(bit r, logic [N-1:0] rd, logic [N-1:0] wr, logic [N-1:0] rel);
    reset = r; core_read_req = rd; core_write_req = wr; core_release = rel;
  endtask

  typedef struct {
    bit           rst;
    logic [N-1:0] rd, wr, rel;
    bit           gv;
    int           gc;
    logic [N-1:0] oh;
    bit           iw, bz, te;
  } vec_t;

  vec_t tv[10];

  initial begin
    drive(1, '0, '0, '0);

    // Directed table: single read grant, ignored foreign release, read+write
    // on one core, requests dropping mid-transaction, cooldown gap.
    tv[0] = '{1, 4'b0000, 4'b0000, 4'b0000, 0, 0, 4'b0000, 0, 0, 0};
    tv[1] = '{0, 4'b0100, 4'b0000, 4'b0000, 1, 2, 4'b0100, 0, 1, 0};
    tv[2] = '{0, 4'b0000, 4'b0000, 4'b1000, 1, 2, 4'b0100, 0, 1, 0};
    tv[3] = '{0, 4'b0000, 4'b0000, 4'b0100, 0, 2, 4'b0000, 0, 1, 0};
    tv[4] = '{0, 4'b0010, 4'b0010, 4'b0000, 0, 2, 4'b0000, 0, 0, 0};
    tv[5] = '{0, 4'b0010, 4'b0010, 4'b0000, 1, 1, 4'b0010, 1, 1, 0};
    tv[6] = '{0, 4'b0000, 4'b0000, 4'b1000, 1, 1, 4'b0010, 1, 1, 0};
    tv[7] = '{0, 4'b0000, 4'b0000, 4'b0010, 0, 1, 4'b0000, 0, 1, 0};
    tv[8] = '{0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 0};
    tv[9] = '{0, 4'b0000, 4'b0000, 4'b0000, 0, 1, 4'b0000, 0, 0, 0};
    for (int i = 0; i < 10; i++) begin
      drive(tv[i].rst, tv[i].rd, tv[i].wr, tv[i].rel);
      step();
      cmp($sformatf("tv%0d_valid", i), int'(grant_valid), int'(tv[i].gv));
      cmp($sformatf("tv%0d_core", i), int'(grant_core), tv[i].gc);
      cmp($sformatf("tv%0d_onehot", i), int'(grant_onehot), int'(tv[i].oh));
      cmp($sformatf("tv%0d_write", i), int'(grant_is_write), int'(tv[i].iw));
      cmp($sformatf("tv%0d_busy", i), int'(busy), int'(tv[i].bz));
      cmp($sformatf("tv%0d_terr", i), int'(timeout_err), int'(tv[i].te));
    end

    // Round robin: all cores request, each released 3 edges after its grant.
    begin
      int order[5] = '{0, 1, 2, 3, 0};
      int gedge[5];
      int ng = 0, since = 0, steps = 0;
      bit prev = 0;
      drive(1, '0, '0, '0); step();
      drive(0, 4'b1111, '0, '0);
      while (ng < 5 && steps < 60) begin
        step(); steps++;
        if (grant_valid && !prev) begin
          cmp($sformatf("rr_core%0d", ng), int'(grant_core), order[ng]);
          gedge[ng] = steps; since = 0;
          if (ng > 0) cmp($sformatf("rr_gap%0d", ng), gedge[ng] - gedge[ng-1], 5);
          ng++;
        end else if (grant_valid) since++;
        prev = grant_valid;
        core_release = (grant_valid && since == 2) ? grant_onehot : '0;
      end
      cmp("rr_grants_seen", ng, 5);
    end

    // Watchdog: core 0 never releases, core 1 waits behind it.
    drive(1, '0, '0, '0); step();
    drive(0, 4'b0011, '0, '0); step();
    cmp("wd_grant_core", int'(grant_core), 0);
    for (int i = 1; i <= 7; i++) step();
    cmp("wd_still_held", int'(grant_valid), 1);
    cmp("wd_terr_clear", int'(timeout_err), 0);
    step();
    cmp("wd_dropped", int'(grant_valid), 0);
    cmp("wd_terr_set", int'(timeout_err), 1);
    step(); step();
    cmp("wd_next_valid", int'(grant_valid), 1);
    cmp("wd_next_core", int'(grant_core), 1);
    cmp("wd_terr_sticky", int'(timeout_err), 1);
    drive(0, '0, '0, 4'b0010); step(); step();

    // Reset while core 3 holds the grant, then cores 0 and 3 compete.
    drive(1, '0, '0, '0); step();
    drive(0, 4'b1000, '0, '0); step();
    cmp("rst_pre_core", int'(grant_core), 3);
    drive(1, 4'b1000, '0, '0); step();
    cmp("rst_valid", int'(grant_valid), 0);
    cmp("rst_core", int'(grant_core), 0);
    cmp("rst_onehot", int'(grant_onehot), 0);
    cmp("rst_busy", int'(busy), 0);
    drive(0, 4'b1001, '0, '0); step();
    cmp("rst_after_core", int'(grant_core), 0);
    cmp("rst_after_valid", int'(grant_valid), 1);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 60) == 0, N'($urandom),
            ($urandom % 3 == 0) ? N'($urandom) : '0,
            ($urandom % 4 == 0) ? N'($urandom) : '0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
